// File: rtl/buffer_fill_engine.sv
// Scratch buffers A/B (32 x 32-bit) with a DMA-style block fill engine and a direct
// pipeline write port; both read ports are combinational for single-cycle MEM loads.
module buffer_fill_engine #(
  parameter int DEPTH       = 32,
  parameter int WORD_STRIDE = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        fill_start,
  input  logic        fill_target,
  input  logic [31:0] fill_base,
  input  logic [5:0]  fill_len,
  output logic        fill_busy,
  output logic        fill_done,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  buf_val_1_addr,
  output logic [31:0] buf_val_1_select,
  input  logic [4:0]  buf_val_2_addr,
  output logic [31:0] buf_val_2_select
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state, next_state;
  logic        target;
  logic [31:0] base;
  logic [5:0]  len;
  logic [5:0]  issue_idx;
  logic [4:0]  cap_idx;
  logic        cap_valid;
  logic        accept;
  logic [5:0]  clamped_len;
  logic [31:0] buf_a [DEPTH];
  logic [31:0] buf_b [DEPTH];

  always_comb begin
    clamped_len = (fill_len > 6'(DEPTH)) ? 6'(DEPTH) : fill_len;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    fill_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          accept     = 1'b1;
          next_state = (clamped_len == 6'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        mem_read  = 1'b1;
        mem_addr  = base + 32'(WORD_STRIDE) * 32'(issue_idx);
        fill_busy = 1'b1;
        if (issue_idx == len - 6'd1) next_state = DRAIN;
      end
      DRAIN: begin
        fill_busy  = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // fill_done is registered off DONE so the pulse lands one cycle after the DONE state
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      fill_done <= 1'b0;
      cap_valid <= 1'b0;
      issue_idx <= '0;
      cap_idx   <= '0;
      target    <= 1'b0;
      base      <= '0;
      len       <= '0;
    end else begin
      state     <= next_state;
      fill_done <= (state == DONE);
      cap_valid <= mem_read;
      if (accept) begin
        target    <= fill_target;
        base      <= fill_base;
        len       <= clamped_len;
        issue_idx <= '0;
        cap_idx   <= '0;
      end else begin
        if (mem_read)  issue_idx <= issue_idx + 6'd1;
        if (cap_valid) cap_idx   <= cap_idx + 5'd1;
      end
    end
  end

  // The pipeline write is issued last so it overrides a capture to the same entry
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else begin
      if (cap_valid) begin
        if (target) buf_b[cap_idx] <= mem_rdata;
        else        buf_a[cap_idx] <= mem_rdata;
      end
      if (wr_en) begin
        if (wr_sel) buf_b[wr_addr] <= wr_data;
        else        buf_a[wr_addr] <= wr_data;
      end
    end
  end

  assign buf_val_1_select = buf_a[buf_val_1_addr];
  assign buf_val_2_select = buf_b[buf_val_2_addr];

endmodule

// File: tb/tb_buffer_fill_engine.sv
// Directed bench for buffer_fill_engine: fills, clamping, write collisions,
// start-while-busy, read timing and mid-fill reset abort.
module tb_buffer_fill_engine;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        fill_start = 1'b0;
  logic        fill_target = 1'b0;
  logic [31:0] fill_base = '0;
  logic [5:0]  fill_len = '0;
  logic        fill_busy, fill_done, mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  buf_val_1_addr = '0;
  logic [4:0]  buf_val_2_addr = '0;
  logic [31:0] buf_val_1_select, buf_val_2_select;

  int errors = 0;
  int checks = 0;

  buffer_fill_engine dut (
    .Clk(Clk), .Rst(Rst),
    .fill_start(fill_start), .fill_target(fill_target), .fill_base(fill_base), .fill_len(fill_len),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .buf_val_1_addr(buf_val_1_addr), .buf_val_1_select(buf_val_1_select),
    .buf_val_2_addr(buf_val_2_addr), .buf_val_2_select(buf_val_2_select)
  );

  always #5 Clk = ~Clk;

  // Memory: word at byte 0x100+4i holds 0xA0000000+i, returned one cycle after the read
  always @(posedge Clk) begin
    if (mem_read) mem_rdata <= 32'hA000_0000 + ((mem_addr - 32'h100) >> 2);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_a(input logic [4:0] idx, output logic [31:0] val);
    buf_val_1_addr = idx;
    #1;
    val = buf_val_1_select;
  endtask

  task automatic read_b(input logic [4:0] idx, output logic [31:0] val);
    buf_val_2_addr = idx;
    #1;
    val = buf_val_2_select;
  endtask

  task automatic count_nonzero(output int n);
    logic [31:0] v;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      read_a(5'(i), v);
      if (v !== 32'h0) n++;
      read_b(5'(i), v);
      if (v !== 32'h0) n++;
    end
  endtask

  // Starts a fill, then watches ncycles sampled cycles; count c is sampled just after edge c
  // (edge 0 being the start edge). wr_at/start_at/rst_at inject events on edge c+1.
  task automatic run_fill(input logic tgt, input logic [31:0] base, input logic [5:0] len,
                          input int wr_at, input int start_at, input int rst_at, input int ncycles,
                          output int done_cycle, output int busy_cnt, output int read_cnt,
                          output int addr_err, output int done_cnt);
    done_cycle = -1; busy_cnt = 0; read_cnt = 0; addr_err = 0; done_cnt = 0;
    fill_start = 1'b1; fill_target = tgt; fill_base = base; fill_len = len;
    tick();
    fill_start = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      if (fill_busy) busy_cnt++;
      if (mem_read) begin
        if (mem_addr !== base + 32'(4 * read_cnt)) addr_err++;
        read_cnt++;
      end
      if (fill_done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      wr_en = (c == wr_at);
      fill_start = (c == start_at);
      if (c == start_at) fill_base = 32'h200;
      Rst = (c == rst_at);
      tick();
    end
    wr_en = 1'b0; fill_start = 1'b0; Rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int dc, bc, rc, ae, dn, nz;

    tick(); tick();
    Rst = 1'b0;
    check("reset_busy", 32'(fill_busy), 32'd0);
    check("reset_done", 32'(fill_done), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    count_nonzero(nz);
    check("reset_buffers_zero", 32'(nz), 32'd0);

    // Pipeline write with no same-cycle bypass
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd5; wr_data = 32'h1234_5678;
    read_a(5'd5, v);
    check("a5_before_edge", v, 32'h0);
    tick();
    wr_en = 1'b0;
    read_a(5'd5, v);
    check("a5_after_edge", v, 32'h1234_5678);
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h55AA_55AA;
    tick();
    wr_en = 1'b0;

    // Basic fill of A, 8 words
    run_fill(1'b0, 32'h100, 6'd8, -1, -1, -1, 14, dc, bc, rc, ae, dn);
    check("fill8_done_cycle", 32'(dc), 32'd10);
    check("fill8_busy_cycles", 32'(bc), 32'd9);
    check("fill8_reads", 32'(rc), 32'd8);
    check("fill8_addr_errs", 32'(ae), 32'd0);
    check("fill8_done_pulses", 32'(dn), 32'd1);
    read_a(5'd0, v); check("fill8_a0", v, 32'hA000_0000);
    read_a(5'd5, v); check("fill8_a5", v, 32'hA000_0005);
    read_a(5'd7, v); check("fill8_a7", v, 32'hA000_0007);
    read_a(5'd8, v); check("fill8_a8_kept", v, 32'h55AA_55AA);

    // Zero-length no-op
    run_fill(1'b0, 32'h100, 6'd0, -1, -1, -1, 6, dc, bc, rc, ae, dn);
    check("len0_done_cycle", 32'(dc), 32'd1);
    check("len0_reads", 32'(rc), 32'd0);
    check("len0_busy_cycles", 32'(bc), 32'd0);
    check("len0_done_pulses", 32'(dn), 32'd1);

    // Oversized length clamps to 32
    run_fill(1'b1, 32'h100, 6'd40, -1, -1, -1, 40, dc, bc, rc, ae, dn);
    check("len40_reads", 32'(rc), 32'd32);
    check("len40_busy_cycles", 32'(bc), 32'd33);
    check("len40_done_cycle", 32'(dc), 32'd34);
    check("len40_addr_errs", 32'(ae), 32'd0);
    read_b(5'd0, v);  check("len40_b0", v, 32'hA000_0000);
    read_b(5'd31, v); check("len40_b31", v, 32'hA000_001F);

    // Write to A[3] while B captures index 3: both land
    wr_sel = 1'b0; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D;
    run_fill(1'b1, 32'h140, 6'd8, 4, -1, -1, 14, dc, bc, rc, ae, dn);
    read_a(5'd3, v); check("other_buf_a3", v, 32'hCAFE_F00D);
    read_b(5'd3, v); check("other_buf_b3", v, 32'hA000_0013);

    // Write to B[3] on the same edge as capture 3: pipeline wins
    wr_sel = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    run_fill(1'b1, 32'h100, 6'd8, 4, -1, -1, 14, dc, bc, rc, ae, dn);
    read_b(5'd3, v); check("collide_b3", v, 32'hDEAD_BEEF);
    read_b(5'd2, v); check("collide_b2", v, 32'hA000_0002);
    read_b(5'd4, v); check("collide_b4", v, 32'hA000_0004);

    // Start pulse during ISSUE is ignored
    run_fill(1'b0, 32'h140, 6'd8, -1, 3, -1, 16, dc, bc, rc, ae, dn);
    check("restart_addr_errs", 32'(ae), 32'd0);
    check("restart_reads", 32'(rc), 32'd8);
    check("restart_done_pulses", 32'(dn), 32'd1);
    check("restart_done_cycle", 32'(dc), 32'd10);
    read_a(5'd7, v); check("restart_a7", v, 32'hA000_0017);

    // Reset on the edge of capture 4 aborts the fill and clears everything
    run_fill(1'b0, 32'h100, 6'd8, -1, -1, 5, 20, dc, bc, rc, ae, dn);
    check("abort_done_pulses", 32'(dn), 32'd0);
    check("abort_busy", 32'(fill_busy), 32'd0);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    read_a(5'd0, v); check("abort_a0", v, 32'h0);
    read_a(5'd3, v); check("abort_a3", v, 32'h0);
    count_nonzero(nz);
    check("abort_buffers_zero", 32'(nz), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
